// File: rtl/eth_tx_fcs_appender_pkg.sv
// Shared constants and FSM state type for the Ethernet TX FCS appender.
// The preamble state is only entered when ETH_TX_PREAMBLE_EN is defined.
package eth_tx_fcs_appender_pkg;

    localparam int DATALEN       = 8;
    localparam int CRC_LEN       = 32;
    localparam int MIN_FRAME_DEF = 60;

    localparam logic [CRC_LEN-1:0] CRC_POLY        = 32'h04C1_1DB7;
    localparam logic [CRC_LEN-1:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [CRC_LEN-1:0] CRC32_INIT      = 32'hFFFF_FFFF;

    localparam logic [DATALEN-1:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [DATALEN-1:0] SFD_BYTE      = 8'hD5;
    localparam int                 PREAMBLE_LEN  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One byte of reflected CRC-32 (poly 0xEDB88320), purely combinational.
module eth_crc32_byte
    import eth_tx_fcs_appender_pkg::*;
(
    input  logic [CRC_LEN-1:0] crc_in,
    input  logic [DATALEN-1:0] data,
    output logic [CRC_LEN-1:0] crc_out
);

    always_comb begin
        logic [CRC_LEN-1:0] c;
        c = crc_in ^ {{(CRC_LEN-DATALEN){1'b0}}, data};
        for (int i = 0; i < DATALEN; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_fcs_appender.sv
// Ethernet TX framing: zero-pads to MIN_FRAME, computes CRC-32 and appends FCS.
// Optional ETH_TX_PREAMBLE_EN prefixes 7x 0x55 + 0xD5 outside the CRC and count.
module eth_tx_fcs_appender
    import eth_tx_fcs_appender_pkg::*;
#(
    parameter int MIN_FRAME = MIN_FRAME_DEF,
    parameter int CNT_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATALEN-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATALEN-1:0] m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [CRC_LEN-1:0] fcs_out,
    output logic [CNT_W-1:0]   frame_len,
    output logic               busy
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);

    state_t             state, state_next;
    logic [DATALEN-1:0] m_data_next;
    logic               m_valid_next, m_last_next;
    logic [CRC_LEN-1:0] crc, crc_next, fcs_next;
    logic [CNT_W-1:0]   cnt, cnt_next, frame_len_next;
    logic [1:0]         idx, idx_next;
`ifdef ETH_TX_PREAMBLE_EN
    logic [2:0]         pre_idx, pre_idx_next;
`endif

    logic               ld, accept;
    logic [CNT_W-1:0]   cnt_base, cnt_inc;
    logic [CRC_LEN-1:0] crc_base, crc_step, crc_inv;
    logic [DATALEN-1:0] crc_byte;

    assign ld = !m_valid || m_ready;
`ifdef ETH_TX_PREAMBLE_EN
    assign s_ready = ld && (state == ST_DATA);
`else
    assign s_ready = ld && (state == ST_IDLE || state == ST_DATA);
`endif
    assign accept = s_valid && s_ready;
    assign busy   = (state != ST_IDLE);

    // A frame starting from IDLE always begins from a fresh count and CRC seed.
    assign cnt_base = (state == ST_IDLE) ? '0 : cnt;
    assign crc_base = (state == ST_IDLE) ? CRC32_INIT : crc;
    assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    assign crc_byte = (state == ST_PAD) ? '0 : s_data;
    assign crc_inv  = ~crc;

    eth_crc32_byte u_crc (
        .crc_in  (crc_base),
        .data    (crc_byte),
        .crc_out (crc_step)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latches are inferred.
        state_next     = state;
        m_data_next    = m_data;
        m_valid_next   = m_valid;
        m_last_next    = m_last;
        crc_next       = crc;
        cnt_next       = cnt;
        idx_next       = idx;
        fcs_next       = fcs_out;
        frame_len_next = frame_len;
`ifdef ETH_TX_PREAMBLE_EN
        pre_idx_next   = pre_idx;
`endif

        if (ld) begin
            m_valid_next = 1'b0;
            m_last_next  = 1'b0;
        end

        if (accept) begin
            m_data_next  = s_data;
            m_valid_next = 1'b1;
            cnt_next     = cnt_inc;
            crc_next     = crc_step;
            state_next   = ST_DATA;
            if (s_last) begin
                idx_next   = '0;
                state_next = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
            end
        end

        case (state)
`ifdef ETH_TX_PREAMBLE_EN
            ST_IDLE: begin
                if (s_valid) begin
                    state_next   = ST_PRE;
                    pre_idx_next = '0;
                end
            end
            ST_PRE: begin
                if (ld) begin
                    m_data_next  = (pre_idx == 3'(PREAMBLE_LEN)) ? SFD_BYTE : PREAMBLE_BYTE;
                    m_valid_next = 1'b1;
                    pre_idx_next = pre_idx + 3'd1;
                    if (pre_idx == 3'(PREAMBLE_LEN)) state_next = ST_DATA;
                end
            end
`endif
            ST_PAD: begin
                if (ld) begin
                    m_data_next  = '0;
                    m_valid_next = 1'b1;
                    crc_next     = crc_step;
                    cnt_next     = cnt_inc;
                    if (cnt_inc == MIN_CNT) begin
                        idx_next   = '0;
                        state_next = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                if (ld) begin
                    m_data_next  = crc_inv[{idx, 3'b000} +: DATALEN];
                    m_valid_next = 1'b1;
                    idx_next     = idx + 2'd1;
                    if (idx == 2'd3) begin
                        m_last_next    = 1'b1;
                        fcs_next       = crc_inv;
                        frame_len_next = cnt;
                        cnt_next       = '0;
                        crc_next       = CRC32_INIT;
                        state_next     = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
        if (rst) begin
            state     <= ST_IDLE;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            crc       <= CRC32_INIT;
            cnt       <= '0;
            idx       <= '0;
            fcs_out   <= '0;
            frame_len <= '0;
`ifdef ETH_TX_PREAMBLE_EN
            pre_idx   <= '0;
`endif
        end else begin
            state     <= state_next;
            m_data    <= m_data_next;
            m_valid   <= m_valid_next;
            m_last    <= m_last_next;
            crc       <= crc_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            fcs_out   <= fcs_next;
            frame_len <= frame_len_next;
`ifdef ETH_TX_PREAMBLE_EN
            pre_idx   <= pre_idx_next;
`endif
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs_appender.sv
// Self-checking bench: random frames and back-pressure against a bit-serial CRC model.
// Two instances cover MIN_FRAME=60 and MIN_FRAME=0 (known-vector check).
module tb_eth_tx_fcs_appender;

    typedef logic [7:0] bq_t[$];

    logic        clk, rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, m_ready;
    logic        use0;

    logic        s_valid_a, s_ready_a, m_valid_a, m_last_a, busy_a;
    logic [7:0]  m_data_a;
    logic [31:0] fcs_a;
    logic [11:0] len_a;
    logic        s_valid_b, s_ready_b, m_valid_b, m_last_b, busy_b;
    logic [7:0]  m_data_b;
    logic [31:0] fcs_b;
    logic [11:0] len_b;

    logic        o_s_ready, o_m_valid, o_m_last, o_busy;
    logic [7:0]  o_m_data;
    logic [31:0] o_fcs;
    logic [11:0] o_len;

    int total = 0;
    int bad   = 0;

    logic [7:0]  in_data[$];
    bit          in_last[$];
    logic [7:0]  exp_data[$];
    bit          exp_last[$];
    logic [7:0]  out_data[$];
    bit          out_last[$];
    int          out_cyc[$];
    logic [31:0] exp_fcs;
    int          exp_len;

    assign s_valid_a = s_valid && !use0;
    assign s_valid_b = s_valid && use0;
    assign o_s_ready = use0 ? s_ready_b : s_ready_a;
    assign o_m_valid = use0 ? m_valid_b : m_valid_a;
    assign o_m_last  = use0 ? m_last_b  : m_last_a;
    assign o_m_data  = use0 ? m_data_b  : m_data_a;
    assign o_fcs     = use0 ? fcs_b     : fcs_a;
    assign o_len     = use0 ? len_b     : len_a;
    assign o_busy    = use0 ? busy_b    : busy_a;

    eth_tx_fcs_appender #(.MIN_FRAME(60), .CNT_W(12)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a), .m_ready(m_ready),
        .fcs_out(fcs_a), .frame_len(len_a), .busy(busy_a)
    );

    eth_tx_fcs_appender #(.MIN_FRAME(0), .CNT_W(12)) dut0 (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready),
        .fcs_out(fcs_b), .frame_len(len_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Bit-serial reference CRC: one message bit at a time, LSB first.
    function automatic logic [31:0] ref_crc(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    function automatic void build_expected(input int min_f);
        bq_t         fr;
        logic [31:0] f;
        exp_data.delete();
        exp_last.delete();
        foreach (in_data[i]) begin
            fr.push_back(in_data[i]);
            if (in_last[i]) begin
                while (fr.size() < min_f) fr.push_back(8'h00);
                f = ~ref_crc(fr);
                foreach (fr[j]) begin
                    exp_data.push_back(fr[j]);
                    exp_last.push_back(1'b0);
                end
                for (int k = 0; k < 4; k++) begin
                    exp_data.push_back(f[8*k +: 8]);
                    exp_last.push_back(k == 3);
                end
                exp_fcs = f;
                exp_len = fr.size();
                fr.delete();
            end
        end
    endfunction

    function automatic void add_frame(input int len);
        for (int i = 0; i < len; i++) begin
            in_data.push_back(8'($urandom_range(255)));
            in_last.push_back(i == len - 1);
        end
    endfunction

    task automatic run_stream(input string name, input int stall_pct, input int min_f);
        int         pi, cyc;
        bit         held_v, held_l;
        logic [7:0] held_d;
        pi = 0; cyc = 0; held_v = 0; held_d = '0; held_l = 0;
        out_data.delete(); out_last.delete(); out_cyc.delete();
        build_expected(min_f);
        @(posedge clk); #1;
        while (out_data.size() < exp_data.size() && cyc < 3000) begin
            s_valid = (pi < in_data.size());
            s_data  = s_valid ? in_data[pi] : 8'h00;
            s_last  = s_valid ? in_last[pi] : 1'b0;
            m_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (held_v) begin
                total++;
                if (o_m_valid !== 1'b1 || o_m_data !== held_d || o_m_last !== held_l) begin
                    bad++;
                    $display("FAIL %s stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             name, o_m_valid, o_m_data, o_m_last, held_d, held_l);
                end
            end
            held_v = o_m_valid && !m_ready;
            held_d = o_m_data;
            held_l = o_m_last;
            if (o_m_valid && m_ready) begin
                out_data.push_back(o_m_data);
                out_last.push_back(o_m_last);
                out_cyc.push_back(cyc);
            end
            if (s_valid && o_s_ready) pi++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 0; s_last = 0; m_ready = 1;
        total++;
        if (cyc >= 3000) begin
            bad++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, out_data.size(), exp_data.size());
        end
    endtask

    task automatic check_stream(input string name);
        total++;
        if (out_data.size() != exp_data.size()) begin
            bad++;
            $display("FAIL %s beat_count: got %0d want %0d", name, out_data.size(), exp_data.size());
        end
        foreach (exp_data[i]) begin
            if (i < out_data.size()) begin
                total++;
                if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                    bad++;
                    $display("FAIL %s beat%0d: got d=%h l=%b want d=%h l=%b",
                             name, i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
                end
            end
        end
        total++;
        if (o_fcs !== exp_fcs) begin
            bad++;
            $display("FAIL %s fcs_out: got %h want %h", name, o_fcs, exp_fcs);
        end
        total++;
        if (o_len !== 12'(exp_len)) begin
            bad++;
            $display("FAIL %s frame_len: got %0d want %0d", name, o_len, exp_len);
        end
    endtask

    task automatic test_reset();
        rst = 1; s_valid = 0; s_last = 0; s_data = '0; m_ready = 1; use0 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        total++;
        if (m_valid_a !== 1'b0 || m_last_a !== 1'b0 || m_data_a !== 8'h00 ||
            m_valid_b !== 1'b0 || m_data_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: got v=%b l=%b d=%h want 0 0 00", m_valid_a, m_last_a, m_data_a);
        end
        total++;
        if (fcs_a !== 32'h0 || len_a !== 12'h0 || fcs_b !== 32'h0 || len_b !== 12'h0) begin
            bad++;
            $display("FAIL reset_status: got fcs=%h len=%0d want 0 0", fcs_a, len_a);
        end
        total++;
        if (busy_a !== 1'b0 || s_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b s_ready=%b want 0 1", busy_a, s_ready_a);
        end
    endtask

    task automatic test_known_vector();
        use0 = 1;
        in_data.delete(); in_last.delete();
        for (int i = 0; i < 9; i++) begin
            in_data.push_back(8'h31 + 8'(i));
            in_last.push_back(i == 8);
        end
        run_stream("known_vec", 0, 0);
        check_stream("known_vec");
        total++;
        if (fcs_b !== 32'hCBF4_3926 || len_b !== 12'd9) begin
            bad++;
            $display("FAIL known_vec_const: got fcs=%h len=%0d want cbf43926 9", fcs_b, len_b);
        end
        use0 = 0;
    endtask

    task automatic test_pad();
        in_data.delete(); in_last.delete();
        add_frame(14);
        run_stream("pad14", 0, 60);
        check_stream("pad14");
        total++;
        if (out_data.size() != 64) begin
            bad++;
            $display("FAIL pad14_beats: got %0d want 64", out_data.size());
        end
    endtask

    task automatic test_no_pad();
        in_data.delete(); in_last.delete();
        add_frame(64);
        run_stream("nopad64", 0, 60);
        check_stream("nopad64");
        total++;
        if (out_data.size() != 68 || o_len !== 12'd64) begin
            bad++;
            $display("FAIL nopad64_len: got beats=%0d len=%0d want 68 64", out_data.size(), o_len);
        end
    endtask

    task automatic test_stall();
        in_data.delete(); in_last.delete();
        add_frame(60);
        run_stream("stall60", 50, 60);
        check_stream("stall60");
    endtask

    task automatic test_back_to_back();
        int k;
        in_data.delete(); in_last.delete();
        add_frame(23);
        add_frame(70);
        run_stream("b2b", 0, 60);
        check_stream("b2b");
        k = -1;
        foreach (out_last[i]) if (out_last[i] && k < 0) k = i;
        total++;
        if (k < 0 || k + 1 >= out_cyc.size() || out_cyc[k+1] != out_cyc[k] + 1) begin
            bad++;
            $display("FAIL b2b_gap: got last_idx=%0d want next beat one cycle after m_last", k);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pi, cyc;
        pi = 0; cyc = 0;
        @(posedge clk); #1;
        m_ready = 1;
        while (pi < 20 && cyc < 200) begin
            s_valid = 1; s_last = 0; s_data = 8'($urandom_range(255));
            @(negedge clk);
            if (s_valid && o_s_ready) pi++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        total++;
        if (m_valid_a !== 1'b0 || busy_a !== 1'b0 || fcs_a !== 32'h0 || len_a !== 12'h0) begin
            bad++;
            $display("FAIL mid_rst: got v=%b busy=%b fcs=%h len=%0d want 0 0 0 0",
                     m_valid_a, busy_a, fcs_a, len_a);
        end
        in_data.delete(); in_last.delete();
        add_frame(25);
        run_stream("after_rst", 0, 60);
        check_stream("after_rst");
    endtask

    initial begin
        clk = 0;
        test_reset();
        test_known_vector();
        test_pad();
        test_no_pad();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
